// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter that merges NUM_REQ valid/ready streams into one registered output stage.
// Packets keep their grant until req_last, or until MAX_BURST beats force rotation to the next requester.
module stream_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_last,
  output logic [ID_WIDTH-1:0]           out_id,
  output logic                          busy
);

  localparam int                  CNT_W    = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [ID_WIDTH-1:0] ID_MAX   = ID_WIDTH'(NUM_REQ - 1);
  localparam logic [ID_WIDTH:0]   NUM_EXT  = (ID_WIDTH+1)'(NUM_REQ);

  typedef enum logic {UNLOCKED, LOCKED} state_e;

  state_e                state_q, state_d;
  logic [ID_WIDTH-1:0]   lock_id_q, lock_id_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [ID_WIDTH-1:0]   out_id_q, out_id_d;

  logic                  locked;
  logic                  stage_ready;
  logic                  accept;
  logic [NUM_REQ-1:0]    valid_rot;
  logic [ID_WIDTH-1:0]   scan_off;
  logic [ID_WIDTH:0]     scan_sum;
  logic [ID_WIDTH-1:0]   scan_sel;
  logic [ID_WIDTH-1:0]   sel;
  logic [DATA_WIDTH-1:0] req_data_arr [NUM_REQ];

  assign locked      = (state_q == LOCKED);
  assign stage_ready = !out_valid_q || out_ready;

  // Rotate so bit 0 is the requester at rr_ptr; the lowest set bit is the winner's offset.
  assign valid_rot = NUM_REQ'({req_valid, req_valid} >> rr_ptr_q);

  always_comb begin
    scan_off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (valid_rot[k]) begin
        scan_off = ID_WIDTH'(k);
      end
    end
  end

  assign scan_sum = {1'b0, rr_ptr_q} + {1'b0, scan_off};
  assign scan_sel = (scan_sum >= NUM_EXT) ? ID_WIDTH'(scan_sum - NUM_EXT) : scan_sum[ID_WIDTH-1:0];
  assign sel      = locked ? lock_id_q : scan_sel;

  // Ready is gated by rst_n so nothing handshakes while reset is held.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign req_data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    assign req_ready[gi]    = rst_n && stage_ready && (sel == ID_WIDTH'(gi))
                              && (locked || req_valid[gi]);
  end

  assign accept = |(req_valid & req_ready);

  always_comb begin
    state_d     = state_q;
    lock_id_d   = lock_id_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = req_data_arr[sel];
      out_last_d  = req_last[sel];
      out_id_d    = sel;
      if (req_last[sel] || (beat_cnt_q == CNT_LAST)) begin
        state_d    = UNLOCKED;
        beat_cnt_d = '0;
        rr_ptr_d   = (sel == ID_MAX) ? '0 : sel + ID_WIDTH'(1);
      end else begin
        state_d    = LOCKED;
        lock_id_d  = sel;
        beat_cnt_d = beat_cnt_q + CNT_W'(1);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= UNLOCKED;
      lock_id_q   <= '0;
      rr_ptr_q    <= '0;
      beat_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      lock_id_q   <= lock_id_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_id    = out_id_q;
  assign busy      = locked || out_valid_q;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Bench for stream_rr_arbiter: directed scenarios plus a randomized run against a packet-level model.
module tb_stream_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MB = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic            out_last;
  logic [IW-1:0]   out_id;
  logic            busy;

  stream_rr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_last(req_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .out_id(out_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Producers: remaining beats of the current packet and a running beat number per requester.
  int rem [N];
  int seq [N];
  int out_seq [N];

  // Reference model: rotation pointer, current packet owner (-1 = none), beats granted so far.
  int            m_ptr, m_owner, m_cnt, m_oid;
  logic          m_ov, m_ol;
  logic [DW-1:0] m_od;

  logic [N-1:0]  exp_ready, obs_ready;
  logic          exp_valid, exp_last, exp_busy, obs_valid, obs_last, obs_busy, delivered;
  logic [DW-1:0] exp_data, obs_data;
  logic [IW-1:0] exp_id, obs_id;

  task automatic model_reset();
    m_ptr = 0; m_owner = -1; m_cnt = 0; m_oid = 0;
    m_ov = 1'b0; m_ol = 1'b0; m_od = '0;
  endtask

  function automatic int model_sel(input logic [N-1:0] v);
    if (m_owner >= 0) return m_owner;
    for (int k = 0; k < N; k++) begin
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  // One clock: drive at the falling edge, sample 1 ns later, advance the model at the rising edge.
  task automatic tick(input logic [N-1:0] want, input logic dr, input logic rst_val);
    int   s;
    logic sr;
    logic acc;
    @(negedge clk);
    rst_n = rst_val;
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = want[i] && (rem[i] > 0);
      req_last[i]           = (rem[i] == 1);
      req_data[i*DW +: DW]  = {8'(i), 24'(seq[i])};
    end
    out_ready = dr;
    #1;
    if (!rst_n) model_reset();
    sr = !m_ov || dr;
    s  = model_sel(req_valid);
    exp_ready = '0;
    if (rst_n && sr && s >= 0 && (m_owner >= 0 || req_valid[s])) exp_ready[s] = 1'b1;
    exp_valid = m_ov;
    exp_data  = m_od;
    exp_last  = m_ol;
    exp_id    = IW'(m_oid);
    exp_busy  = (m_owner >= 0) || m_ov;
    obs_ready = req_ready;
    obs_valid = out_valid;
    obs_data  = out_data;
    obs_last  = out_last;
    obs_id    = out_id;
    obs_busy  = busy;
    delivered = obs_valid && dr;
    @(posedge clk);
    acc = rst_n && (s >= 0) && sr && req_valid[s];
    if (acc) begin
      m_ov  = 1'b1;
      m_od  = {8'(s), 24'(seq[s])};
      m_ol  = (rem[s] == 1);
      m_oid = s;
      if (rem[s] == 1 || m_cnt == MB - 1) begin
        m_owner = -1; m_cnt = 0; m_ptr = (s + 1) % N;
      end else begin
        m_owner = s; m_cnt = m_cnt + 1;
      end
      rem[s] = rem[s] - 1;
      seq[s] = seq[s] + 1;
    end else if (rst_n && dr) begin
      m_ov = 1'b0;
    end
  endtask

  task automatic reset_all();
    for (int i = 0; i < N; i++) begin
      rem[i] = 0; seq[i] = 0; out_seq[i] = 0;
    end
    tick('0, 1'b1, 1'b0);
    tick('0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) begin
      rem[i] = 5; seq[i] = 0; out_seq[i] = 0;
    end
    tick(4'hF, 1'b1, 1'b0);
    n_vec++;
    if (obs_ready !== 4'b0000) begin
      n_err++; $display("FAIL reset_ready got=%b want=0000", obs_ready);
    end
    n_vec++;
    if ({obs_valid, obs_busy, obs_last} !== 3'b000 || obs_data !== '0 || obs_id !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got valid=%b busy=%b last=%b data=%h id=%0d want all zero",
               obs_valid, obs_busy, obs_last, obs_data, obs_id);
    end
    tick(4'hF, 1'b1, 1'b1);
    n_vec++;
    if (obs_ready !== 4'b0001) begin
      n_err++; $display("FAIL reset_first_grant got=%b want=0001", obs_ready);
    end
    tick(4'hF, 1'b1, 1'b1);
    n_vec++;
    if (obs_valid !== 1'b1 || obs_id !== 2'd0) begin
      n_err++; $display("FAIL reset_first_id got valid=%b id=%0d want valid=1 id=0", obs_valid, obs_id);
    end
  endtask

  task automatic test_round_robin();
    int ids[$];
    int want_ids [5] = '{0, 1, 2, 3, 0};
    reset_all();
    for (int c = 0; c < 7; c++) begin
      for (int i = 0; i < N; i++) rem[i] = 1;
      tick(4'hF, 1'b1, 1'b1);
      if (c == 0) begin
        n_vec++;
        if (obs_valid !== 1'b0) begin
          n_err++; $display("FAIL rr_latency_c0 got valid=%b want 0", obs_valid);
        end
      end
      if (c == 1) begin
        n_vec++;
        if (obs_valid !== 1'b1) begin
          n_err++; $display("FAIL rr_latency_c1 got valid=%b want 1", obs_valid);
        end
      end
      if (delivered) ids.push_back(int'(obs_id));
    end
    n_vec++;
    if (ids.size() < 6) begin
      n_err++; $display("FAIL rr_throughput got %0d beats want 6", ids.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        n_vec++;
        if (ids[k] != want_ids[k]) begin
          n_err++; $display("FAIL rr_order beat=%0d got id=%0d want %0d", k, ids[k], want_ids[k]);
        end
      end
    end
  endtask

  task automatic test_burst_cap();
    int ids[$];
    int lasts[$];
    int want_ids   [7] = '{1, 1, 1, 1, 2, 1, 1};
    int want_lasts [7] = '{0, 0, 0, 0, 1, 0, 1};
    reset_all();
    rem[1] = 6; rem[2] = 1;
    for (int c = 0; c < 20 && ids.size() < 7; c++) begin
      tick(4'hF, 1'b1, 1'b1);
      if (delivered) begin
        ids.push_back(int'(obs_id));
        lasts.push_back(int'(obs_last));
      end
    end
    n_vec++;
    if (ids.size() != 7) begin
      n_err++; $display("FAIL burst_timeout got %0d beats want 7", ids.size());
    end else begin
      for (int k = 0; k < 7; k++) begin
        n_vec++;
        if (ids[k] != want_ids[k] || lasts[k] != want_lasts[k]) begin
          n_err++;
          $display("FAIL burst_beat beat=%0d got id=%0d last=%0d want id=%0d last=%0d",
                   k, ids[k], lasts[k], want_ids[k], want_lasts[k]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] held_data;
    logic [IW-1:0] held_id;
    int            n_del = 0;
    logic          dr;
    reset_all();
    for (int i = 0; i < N; i++) rem[i] = 8;
    held_data = '0; held_id = '0;
    for (int c = 0; c < 50; c++) begin
      dr = !(c >= 3 && c < 8);
      tick(4'hF, dr, 1'b1);
      if (!dr) begin
        n_vec++;
        if (obs_valid !== 1'b1 || obs_ready !== 4'b0000) begin
          n_err++; $display("FAIL stall_ctrl c=%0d got valid=%b ready=%b want 1/0000", c, obs_valid, obs_ready);
        end
        if (c == 3) begin
          held_data = obs_data; held_id = obs_id;
        end else begin
          n_vec++;
          if (obs_data !== held_data || obs_id !== held_id) begin
            n_err++;
            $display("FAIL stall_hold c=%0d got data=%h id=%0d want data=%h id=%0d",
                     c, obs_data, obs_id, held_data, held_id);
          end
        end
      end
      if (delivered) begin
        n_del++;
        n_vec++;
        if (obs_data !== {8'(obs_id), 24'(out_seq[obs_id])}) begin
          n_err++; $display("FAIL bp_scoreboard id=%0d got data=%h want seq %0d", obs_id, obs_data, out_seq[obs_id]);
        end
        out_seq[obs_id]++;
      end
    end
    n_vec++;
    if (n_del != 4 * 8) begin
      n_err++; $display("FAIL bp_count got %0d beats want 32", n_del);
    end
  endtask

  task automatic test_lock_hold();
    int ids[$];
    int want_ids [5] = '{0, 0, 0, 3, 3};
    reset_all();
    rem[0] = 3; rem[3] = 2;
    tick(4'b1001, 1'b1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      tick(4'b1000, 1'b1, 1'b1);
      n_vec++;
      if (obs_ready !== 4'b0001) begin
        n_err++; $display("FAIL lock_hold_ready c=%0d got=%b want=0001", c, obs_ready);
      end
      if (delivered) ids.push_back(int'(obs_id));
    end
    for (int c = 0; c < 15 && ids.size() < 5; c++) begin
      tick(4'hF, 1'b1, 1'b1);
      if (delivered) ids.push_back(int'(obs_id));
    end
    n_vec++;
    if (ids.size() != 5) begin
      n_err++; $display("FAIL lock_timeout got %0d beats want 5", ids.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        n_vec++;
        if (ids[k] != want_ids[k]) begin
          n_err++; $display("FAIL lock_order beat=%0d got id=%0d want %0d", k, ids[k], want_ids[k]);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    int first_id = -1;
    reset_all();
    rem[1] = 10;
    for (int c = 0; c < 3; c++) tick(4'hF, 1'b1, 1'b1);
    tick(4'hF, 1'b1, 1'b0);
    n_vec++;
    if (obs_valid !== 1'b0 || obs_busy !== 1'b0 || obs_ready !== 4'b0000) begin
      n_err++;
      $display("FAIL midreset_outputs got valid=%b busy=%b ready=%b want 0/0/0000", obs_valid, obs_busy, obs_ready);
    end
    tick(4'hF, 1'b1, 1'b0);
    rem[0] = 1;
    for (int c = 0; c < 10 && first_id < 0; c++) begin
      tick(4'hF, 1'b1, 1'b1);
      if (delivered) first_id = int'(obs_id);
    end
    n_vec++;
    if (first_id != 0) begin
      n_err++; $display("FAIL midreset_scan got first id=%0d want 0", first_id);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] want;
    logic         dr;
    reset_all();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (rem[i] == 0 && $urandom_range(0, 3) == 0) rem[i] = $urandom_range(1, 7);
      end
      want = N'($urandom);
      dr   = ($urandom_range(0, 9) < 7);
      tick(want, dr, 1'b1);
      n_vec++;
      if (obs_ready !== exp_ready) begin
        n_err++; $display("FAIL rnd_ready c=%0d got=%b want=%b", c, obs_ready, exp_ready);
      end
      n_vec++;
      if (obs_valid !== exp_valid || obs_busy !== exp_busy) begin
        n_err++;
        $display("FAIL rnd_valid_busy c=%0d got %b/%b want %b/%b", c, obs_valid, obs_busy, exp_valid, exp_busy);
      end
      if (exp_valid) begin
        n_vec++;
        if (obs_data !== exp_data || obs_last !== exp_last || obs_id !== exp_id) begin
          n_err++;
          $display("FAIL rnd_beat c=%0d got data=%h last=%b id=%0d want data=%h last=%b id=%0d",
                   c, obs_data, obs_last, obs_id, exp_data, exp_last, exp_id);
        end
      end
      if (delivered) begin
        n_vec++;
        if (obs_data !== {8'(obs_id), 24'(out_seq[obs_id])}) begin
          n_err++; $display("FAIL rnd_scoreboard c=%0d id=%0d got data=%h want seq %0d", c, obs_id, obs_data, out_seq[obs_id]);
        end
        out_seq[obs_id]++;
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    out_ready = 1'b0;
    model_reset();
    test_reset();
    test_round_robin();
    test_burst_cap();
    test_backpressure();
    test_lock_hold();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
